// File: rtl/mem_pkg.sv
// Shared memory-side definitions for the store buffer: widths, default
// depth, the buffered entry record and the data-memory port operation.
package mem_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned SB_DEPTH = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    localparam int unsigned ENTRY_W = $bits(sb_entry_t);

    // Which client owns the data-memory port in a given cycle.
    typedef enum logic [1:0] {
        MEM_IDLE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_op_t;

    // Absolute byte distance between two addresses.
    function automatic logic [ADDR_W-1:0] addr_dist(input logic [ADDR_W-1:0] a,
                                                    input logic [ADDR_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sb_match.sv
// Load-address comparator across all live store-buffer entries.
// Reports an exact hit (with the youngest matching data) and any
// partial-overlap conflict (different address within one word).
module sb_match
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = PTR_W + 1
) (
    input  logic [DEPTH-1:0][ENTRY_W-1:0] entries_i,
    input  logic [PTR_W-1:0]              rd_ptr_i,
    input  logic [CNT_W-1:0]              count_i,
    input  logic [ADDR_W-1:0]             addr_i,
    output logic                          hit_o,
    output logic [DATA_W-1:0]             data_o,
    output logic                          conflict_o
);

    logic [PTR_W-1:0] idx;
    sb_entry_t        ent;

    // Walk entries oldest to youngest so a later (younger) match overrides.
    always_comb begin
        hit_o      = 1'b0;
        data_o     = '0;
        conflict_o = 1'b0;
        idx        = '0;
        ent        = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_i + PTR_W'(k);
            ent = sb_entry_t'(entries_i[idx]);
            if (CNT_W'(k) < count_i) begin
                if (ent.addr == addr_i) begin
                    hit_o  = 1'b1;
                    data_o = ent.data;
                end else if (addr_dist(ent.addr, addr_i) < ADDR_W'(4)) begin
                    conflict_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// MEM-stage store buffer: queues stores in a circular FIFO, drains them to
// data memory in idle load slots, forwards exact-match loads and stalls on
// partially overlapping loads until the conflicting entries have drained.
module store_buffer
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        st_valid_i,
    input  logic [31:0] st_addr_i,
    input  logic [31:0] st_data_i,
    input  logic        ld_valid_i,
    input  logic [31:0] ld_addr_i,
    output logic        stall_o,
    output logic        fwd_hit_o,
    output logic [31:0] fwd_data_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ENTRY_W-1:0] entries_q, entries_d;
    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]              count_q, count_d;

    logic        match_hit;
    logic [31:0] match_data;
    logic        match_conflict;

    logic        ld_act, st_act, full, conflict, enq, drain;
    sb_entry_t   head;
    mem_op_t     op;

    sb_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_match (
        .entries_i  (entries_q),
        .rd_ptr_i   (rd_ptr_q),
        .count_i    (count_q),
        .addr_i     (ld_addr_i),
        .hit_o      (match_hit),
        .data_o     (match_data),
        .conflict_o (match_conflict)
    );

    // Request arbitration, memory-port ownership and next FIFO state.
    // While rst_i is low every request is masked so outputs sit at idle values.
    always_comb begin
        ld_act   = rst_i & ld_valid_i;
        st_act   = rst_i & st_valid_i;
        full     = (count_q == CNT_W'(DEPTH));
        head     = sb_entry_t'(entries_q[rd_ptr_q]);
        conflict = ld_act & match_conflict;
        stall_o  = (st_act & full) | conflict;
        enq      = st_act & ~stall_o;
        drain    = rst_i & (count_q != '0) & (~ld_act | conflict);

        if (drain) begin
            op = MEM_WRITE;
        end else if (ld_act & ~conflict) begin
            op = MEM_READ;
        end else begin
            op = MEM_IDLE;
        end

        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        unique case (op)
            MEM_WRITE: begin
                mem_write_o = 1'b1;
                mem_addr_o  = head.addr;
                mem_data_o  = head.data;
            end
            MEM_READ: begin
                mem_read_o = 1'b1;
                mem_addr_o = ld_addr_i;
            end
            default: ;
        endcase

        fwd_hit_o  = ld_act & ~conflict & match_hit;
        fwd_data_o = fwd_hit_o ? match_data : '0;
        empty_o    = ~rst_i | (count_q == '0);

        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (enq) begin
            entries_d[wr_ptr_q] = {st_addr_i, st_data_i};
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        if (drain) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({enq, drain})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            entries_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule
